// File: rtl/dev_bus_router.sv
// dev_bus_router: decodes one arbitrated request onto NDEV device ports and always returns a response,
// substituting ERR_DATA for unmapped addresses and for devices that stay silent past the timeout.
module dev_bus_router #(
    parameter int XLEN = 32,
    parameter int NDEV = 4,
    parameter logic [3:0] DEV_PREFIX = 4'hC,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [XLEN-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ARB_strobe_i,
    input  logic [XLEN-1:0]      ARB_addr_i,
    input  logic                 ARB_rw_i,
    input  logic [XLEN/8-1:0]    ARB_byte_enable_i,
    input  logic [XLEN-1:0]      ARB_data_i,
    output logic                 ARB_data_ready_o,
    output logic [XLEN-1:0]      ARB_data_o,
    output logic [NDEV-1:0]      D_strobe_o,
    output logic [XLEN-1:0]      D_addr_o,
    output logic                 D_rw_o,
    output logic [XLEN/8-1:0]    D_byte_enable_o,
    output logic [XLEN-1:0]      D_data_o,
    input  logic [NDEV-1:0]      D_data_ready_i,
    input  logic [NDEV*XLEN-1:0] D_data_i,
    output logic                 err_o,
    output logic [XLEN-1:0]      err_addr_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [4:0] NDEV_W = 5'(NDEV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, err_addr_q, err_addr_d;
    logic              rw_q, rw_d, err_q, err_d;
    logic [XLEN/8-1:0] be_q, be_d;
    logic [3:0]        idx_q, idx_d, req_idx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              hit, sel_rdy, err_now;
    logic [XLEN-1:0]   sel_data, err_at;

    assign req_idx = ARB_addr_i[XLEN-5 -: 4];
    assign hit = (ARB_addr_i[XLEN-1 -: 4] == DEV_PREFIX) && ({1'b0, req_idx} < NDEV_W);

    always_comb begin
        sel_rdy = 1'b0;
        sel_data = '0;
        for (int k = 0; k < NDEV; k++) begin
            if (idx_q == 4'(k)) begin
                sel_rdy = D_data_ready_i[k];
                sel_data = D_data_i[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        rw_d = rw_q;
        be_d = be_q;
        wdata_d = wdata_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        rdata_d = rdata_q;
        err_d = err_q;
        err_addr_d = err_addr_q;
        err_now = 1'b0;
        err_at = '0;
        case (state_q)
            IDLE: if (ARB_strobe_i) begin
                addr_d = ARB_addr_i;
                rw_d = ARB_rw_i;
                be_d = ARB_byte_enable_i;
                wdata_d = ARB_data_i;
                idx_d = req_idx;
                state_d = hit ? ISSUE : RESP;
                if (!hit) begin
                    rdata_d = ERR_DATA;
                    err_now = 1'b1;
                    err_at = ARB_addr_i;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d = '0;
            end
            WAIT: begin
                // a ready on the last count cycle takes priority over the timeout
                if (sel_rdy) begin
                    rdata_d = sel_data;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = ERR_DATA;
                    err_now = 1'b1;
                    err_at = addr_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (err_now && !err_q) begin
            err_d = 1'b1;
            err_addr_d = err_at;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q <= '0;
            rw_q <= 1'b0;
            be_q <= '0;
            wdata_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            rw_q <= rw_d;
            be_q <= be_d;
            wdata_q <= wdata_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign ARB_data_ready_o = (state_q == RESP);
    assign ARB_data_o = rdata_q;
    assign D_strobe_o = (state_q == ISSUE) ? (NDEV'(1) << idx_q) : '0;
    assign D_addr_o = addr_q;
    assign D_rw_o = rw_q;
    assign D_byte_enable_o = be_q;
    assign D_data_o = wdata_q;
    assign err_o = err_q;
    assign err_addr_o = err_addr_q;
endmodule

// File: tb/tb_dev_bus_router.sv
// tb_dev_bus_router: randomized and directed transactions checked against a cycle-latency model of the router.
module tb_dev_bus_router;
    localparam int TO = 8;
    localparam int LOOP = TO + 10;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk = 1'b0, rst = 1'b0;
    logic stb = 1'b0, rw = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0] be = '0;
    logic [3:0] d_rdy = '0;
    logic [127:0] d_data = '0;
    logic arb_rdy, d_rw, err;
    logic [31:0] arb_data, d_addr, d_wdata, err_addr;
    logic [3:0] d_stb, d_be;

    int errors = 0, checks = 0;
    int o_resp_cyc, o_resp_cnt, o_stb_cyc, o_stb_cnt;
    logic [31:0] o_resp_data, o_daddr, o_ddata;
    logic [3:0] o_stb_val, o_dbe;
    logic o_drw;
    logic m_err = 1'b0;
    logic [31:0] m_err_addr = '0;

    dev_bus_router #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .ARB_strobe_i(stb), .ARB_addr_i(addr), .ARB_rw_i(rw), .ARB_byte_enable_i(be), .ARB_data_i(wdata),
        .ARB_data_ready_o(arb_rdy), .ARB_data_o(arb_data),
        .D_strobe_o(d_stb), .D_addr_o(d_addr), .D_rw_o(d_rw), .D_byte_enable_o(d_be), .D_data_o(d_wdata),
        .D_data_ready_i(d_rdy), .D_data_i(d_data),
        .err_o(err), .err_addr_o(err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic m_hit(logic [31:0] a);
        return a[31:28] == 4'hC && a[27:24] < 4;
    endfunction
    function automatic logic m_is_err(logic [31:0] a, int k);
        return !m_hit(a) || k > TO + 1;
    endfunction
    function automatic int m_lat(logic [31:0] a, int k);
        return !m_hit(a) ? 1 : (k <= TO + 1 ? k + 1 : TO + 2);
    endfunction
    function automatic logic [31:0] m_data(logic [31:0] a, int k, logic [31:0] rd);
        return m_is_err(a, k) ? ERR : rd;
    endfunction
    function automatic logic [3:0] m_stb(logic [31:0] a);
        return m_hit(a) ? (4'b1 << a[27:24]) : 4'b0;
    endfunction

    task automatic m_log(logic [31:0] a, int k);
        if (m_is_err(a, k) && !m_err) begin
            m_err = 1'b1;
            m_err_addr = a;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        stb = 1'b0;
        d_rdy = '0;
        @(negedge clk);
        rst = 1'b0;
        m_err = 1'b0;
        m_err_addr = '0;
    endtask

    // Strobe at cycle 0; device rdev raises ready for one cycle at cycle rk; noise device is ready every cycle.
    task automatic xact(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] wd,
                        input int rdev, input int rk, input logic [31:0] rd, input int noise);
        @(negedge clk);
        stb = 1'b1; addr = a; rw = w; be = b; wdata = wd; d_rdy = '0;
        o_resp_cyc = -1; o_resp_cnt = 0; o_stb_cyc = -1; o_stb_cnt = 0; o_resp_data = '0; o_stb_val = '0;
        for (int c = 1; c <= LOOP; c++) begin
            @(negedge clk);
            if (arb_rdy) begin
                if (o_resp_cnt == 0) begin
                    o_resp_cyc = c;
                    o_resp_data = arb_data;
                end
                o_resp_cnt++;
            end
            if (|d_stb) begin
                if (o_stb_cnt == 0) begin
                    o_stb_cyc = c; o_stb_val = d_stb;
                    o_daddr = d_addr; o_drw = d_rw; o_dbe = d_be; o_ddata = d_wdata;
                end
                o_stb_cnt++;
            end
            stb = 1'b0;
            addr = $urandom; wdata = $urandom; rw = 1'($urandom); be = 4'($urandom);
            d_rdy = '0;
            for (int i = 0; i < 4; i++) d_data[i*32 +: 32] = $urandom;
            if (noise >= 0 && noise < 4) begin
                d_rdy[noise] = 1'b1;
                d_data[noise*32 +: 32] = 32'hFFFF_FFFF;
            end
            if (c == rk && rdev >= 0 && rdev < 4) begin
                d_rdy[rdev] = 1'b1;
                d_data[rdev*32 +: 32] = rd;
            end
        end
        d_rdy = '0;
        m_log(a, rk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (arb_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", arb_rdy); end
        checks++; if (arb_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", arb_data); end
        checks++; if (d_stb !== 4'h0) begin errors++; $display("FAIL reset_stb got=%b exp=0", d_stb); end
        checks++; if ({d_addr, d_rw, d_be, d_wdata} !== '0) begin errors++; $display("FAIL reset_dbus got=%h/%b/%h/%h exp=0", d_addr, d_rw, d_be, d_wdata); end
        checks++; if ({err, err_addr} !== '0) begin errors++; $display("FAIL reset_err got=%b/%h exp=0", err, err_addr); end
        rst = 1'b0;
    endtask

    task automatic test_read();
        xact(32'hC100_0010, 1'b0, 4'hF, 32'h0, 1, 4, 32'h1234_5678, -1);
        checks++; if (o_stb_cyc !== 1 || o_stb_val !== 4'b0010 || o_stb_cnt !== 1) begin errors++; $display("FAIL read_stb got cyc=%0d val=%b n=%0d exp cyc=1 val=0010 n=1", o_stb_cyc, o_stb_val, o_stb_cnt); end
        checks++; if (o_resp_cyc !== 5 || o_resp_cnt !== 1) begin errors++; $display("FAIL read_lat got cyc=%0d n=%0d exp cyc=5 n=1", o_resp_cyc, o_resp_cnt); end
        checks++; if (o_resp_data !== 32'h1234_5678) begin errors++; $display("FAIL read_data got=%h exp=12345678", o_resp_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_err got=%b exp=0", err); end
        checks++; if (arb_data !== 32'h1234_5678) begin errors++; $display("FAIL read_hold got=%h exp=12345678", arb_data); end
    endtask

    task automatic test_write();
        xact(32'hC000_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5, 0, 2, 32'h0, -1);
        checks++; if (o_stb_val !== 4'b0001 || o_stb_cnt !== 1) begin errors++; $display("FAIL write_stb got=%b n=%0d exp=0001 n=1", o_stb_val, o_stb_cnt); end
        checks++; if ({o_daddr, o_drw, o_dbe, o_ddata} !== {32'hC000_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5}) begin errors++; $display("FAIL write_dbus got=%h/%b/%b/%h exp=c0000004/1/0011/a5a5a5a5", o_daddr, o_drw, o_dbe, o_ddata); end
        checks++; if (o_resp_cyc !== 3 || o_resp_cnt !== 1) begin errors++; $display("FAIL write_lat got cyc=%0d n=%0d exp cyc=3 n=1", o_resp_cyc, o_resp_cnt); end
        checks++; if ({d_addr, d_rw, d_be, d_wdata} !== {32'hC000_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5}) begin errors++; $display("FAIL write_dbus_hold got=%h/%b/%b/%h exp=c0000004/1/0011/a5a5a5a5", d_addr, d_rw, d_be, d_wdata); end
    endtask

    task automatic test_unmapped();
        xact(32'hC500_0000, 1'b0, 4'hF, 32'h0, -1, 0, 32'h0, -1);
        checks++; if (o_resp_cyc !== 1 || o_resp_cnt !== 1 || o_resp_data !== ERR) begin errors++; $display("FAIL unmap_resp got cyc=%0d n=%0d data=%h exp cyc=1 n=1 data=deadbeef", o_resp_cyc, o_resp_cnt, o_resp_data); end
        checks++; if (o_stb_cnt !== 0) begin errors++; $display("FAIL unmap_stb got n=%0d exp=0", o_stb_cnt); end
        checks++; if (err !== 1'b1 || err_addr !== 32'hC500_0000) begin errors++; $display("FAIL unmap_err got=%b/%h exp=1/c5000000", err, err_addr); end
        xact(32'h8000_0000, 1'b0, 4'hF, 32'h0, -1, 0, 32'h0, -1);
        checks++; if (o_resp_cyc !== 1 || o_resp_data !== ERR) begin errors++; $display("FAIL unmap2_resp got cyc=%0d data=%h exp cyc=1 data=deadbeef", o_resp_cyc, o_resp_data); end
        checks++; if (err !== 1'b1 || err_addr !== 32'hC500_0000) begin errors++; $display("FAIL unmap2_sticky got=%b/%h exp=1/c5000000", err, err_addr); end
    endtask

    task automatic test_timeout();
        do_reset();
        xact(32'hC200_0040, 1'b0, 4'hF, 32'h0, 2, TO + 4, 32'h7777_7777, -1);
        checks++; if (o_resp_cyc !== TO + 2 || o_resp_cnt !== 1) begin errors++; $display("FAIL timeout_lat got cyc=%0d n=%0d exp cyc=%0d n=1", o_resp_cyc, o_resp_cnt, TO + 2); end
        checks++; if (o_resp_data !== ERR || arb_data !== ERR) begin errors++; $display("FAIL timeout_data got=%h/%h exp=deadbeef", o_resp_data, arb_data); end
        checks++; if (err !== 1'b1 || err_addr !== 32'hC200_0040) begin errors++; $display("FAIL timeout_err got=%b/%h exp=1/c2000040", err, err_addr); end
    endtask

    task automatic test_wrong_dev();
        xact(32'hC300_0000, 1'b0, 4'hF, 32'h0, 3, 6, 32'h0000_0042, 0);
        checks++; if (o_resp_cyc !== 7 || o_resp_data !== 32'h42) begin errors++; $display("FAIL wrongdev got cyc=%0d data=%h exp cyc=7 data=00000042", o_resp_cyc, o_resp_data); end
        xact(32'hC100_0000, 1'b0, 4'hF, 32'h0, 1, TO + 1, 32'h0BAD_CAFE, 2);
        checks++; if (o_resp_cyc !== TO + 2 || o_resp_data !== 32'h0BAD_CAFE) begin errors++; $display("FAIL last_count got cyc=%0d data=%h exp cyc=%0d data=0badcafe", o_resp_cyc, o_resp_data, TO + 2); end
        xact(32'hC100_0000, 1'b0, 4'hF, 32'h0, 1, TO + 2, 32'h0BAD_CAFE, -1);
        checks++; if (o_resp_cyc !== TO + 2 || o_resp_data !== ERR) begin errors++; $display("FAIL past_count got cyc=%0d data=%h exp cyc=%0d data=deadbeef", o_resp_cyc, o_resp_data, TO + 2); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, rd;
            logic w;
            int k, nz;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31:28] = 4'hC;
            a[27:24] = 4'($urandom_range(0, 5));
            w = 1'($urandom);
            k = $urandom_range(2, TO + 3);
            rd = $urandom;
            nz = $urandom_range(0, 4);
            if (nz == a[27:24] || nz == 4) nz = -1;
            xact(a, w, 4'($urandom), $urandom, a[27:24], k, rd, nz);
            checks++; if (o_resp_cyc !== m_lat(a, k) || o_resp_cnt !== 1) begin errors++; $display("FAIL rand_lat a=%h k=%0d got cyc=%0d n=%0d exp cyc=%0d n=1", a, k, o_resp_cyc, o_resp_cnt, m_lat(a, k)); end
            checks++; if (o_stb_val !== m_stb(a) || o_stb_cnt !== (m_hit(a) ? 1 : 0)) begin errors++; $display("FAIL rand_stb a=%h got=%b n=%0d exp=%b", a, o_stb_val, o_stb_cnt, m_stb(a)); end
            if (!w || m_is_err(a, k)) begin
                checks++; if (o_resp_data !== m_data(a, k, rd)) begin errors++; $display("FAIL rand_data a=%h k=%0d got=%h exp=%h", a, k, o_resp_data, m_data(a, k, rd)); end
            end
            checks++; if (err !== m_err || err_addr !== m_err_addr) begin errors++; $display("FAIL rand_err got=%b/%h exp=%b/%h", err, err_addr, m_err, m_err_addr); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        stb = 1'b1; addr = 32'hC100_0000; rw = 1'b1; be = 4'hF; wdata = 32'h1111_2222;
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({arb_rdy, arb_data, d_stb} !== '0) begin errors++; $display("FAIL midrst_arb got=%b/%h/%b exp=0", arb_rdy, arb_data, d_stb); end
        checks++; if ({d_addr, d_rw, d_be, d_wdata, err, err_addr} !== '0) begin errors++; $display("FAIL midrst_dbus got=%h/%b/%h/%h/%b/%h exp=0", d_addr, d_rw, d_be, d_wdata, err, err_addr); end
        rst = 1'b0;
        m_err = 1'b0;
        m_err_addr = '0;
        xact(32'hC100_0008, 1'b0, 4'hF, 32'h0, 1, 3, 32'hCAFE_F00D, -1);
        checks++; if (o_resp_cyc !== 4 || o_resp_cnt !== 1 || o_resp_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL midrst_next got cyc=%0d n=%0d data=%h exp cyc=4 n=1 data=cafef00d", o_resp_cyc, o_resp_cnt, o_resp_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b exp=0", err); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_wrong_dev();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dev_bus_router.md
Name: dev_bus_router

Overview:
- Sits directly downstream of the multi-core bus arbiter.
- Takes the single arbitrated device request and decodes its address into one of NDEV device slave ports (UART, SPI, CLINT, ...).
- Forwards the request as a one-cycle strobe and returns the selected device's data/ready to the arbiter.
- Guarantees a response for unmapped addresses and hung devices, using an error word and a timeout, so the arbiter's WAIT state can never deadlock.

Parameters:
XLEN, 32, data/address width
NDEV, 4, number of device slave ports (1..16)
DEV_PREFIX, 4'hC, value of addr[XLEN-1:XLEN-4] identifying device space
TIMEOUT_CYCLES, 1024, max cycles in WAIT before forced error response (>=2)
ERR_DATA, 32'hDEAD_BEEF, read data returned on unmapped/timeout

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
ARB_strobe_i  in  1  request pulse from arbiter
ARB_addr_i  in  XLEN  request address
ARB_rw_i  in  1  1=write, 0=read
ARB_byte_enable_i  in  XLEN/8  byte enables
ARB_data_i  in  XLEN  write data
ARB_data_ready_o  out  1  one-cycle response pulse to arbiter
ARB_data_o  out  XLEN  response read data
D_strobe_o  out  NDEV  one-hot strobe, one bit per device
D_addr_o  out  XLEN  shared address to devices
D_rw_o  out  1  shared rw
D_byte_enable_o  out  XLEN/8  shared byte enables
D_data_o  out  XLEN  shared write data
D_data_ready_i  in  NDEV  per-device ready
D_data_i  in  NDEV*XLEN  per-device read data, device k at [k*XLEN +: XLEN]
err_o  out  1  sticky error flag, cleared only by reset
err_addr_o  out  XLEN  address of the first erroring request

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On ARB_strobe_i, capture addr/rw/be/data into registers and decode.
  - Hit when addr[XLEN-1:XLEN-4]==DEV_PREFIX and idx=addr[27:24] < NDEV.
  - Hit -> ISSUE. Miss -> RESP with ARB_data_o=ERR_DATA and error logged.
- ISSUE:
  - D_strobe_o[idx]=1 for exactly this cycle; D_addr/rw/be/data_o driven from the captured registers.
  - Next state is WAIT; counter cleared.
- WAIT:
  - Only D_data_ready_i[idx] is honoured. Other devices' ready bits are ignored.
  - On ready: capture D_data_i slice idx into ARB_data_o -> RESP.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 and ready is low: ARB_data_o=ERR_DATA, error logged -> RESP.
  - Ready arriving on the final count cycle wins over the timeout.
- RESP: ARB_data_ready_o=1 for exactly one cycle -> IDLE.
- ARB_data_o holds its value until the next capture.
- D_addr/rw/be/data_o hold the captured values between requests.
- Latency:
  - Strobe at cycle T -> D_strobe at T+1.
  - Device ready at T+k (k>=2) -> ARB_data_ready_o at T+k+1.
  - Unmapped address -> ARB_data_ready_o at T+1.
- Writes follow the same handshake; ARB_data_o on a write is don't-care except on error, where it is ERR_DATA.
- Error logging: on the first error since reset, set err_o and load err_addr_o. Later errors leave err_addr_o unchanged.
- ARB_strobe_i outside IDLE is ignored and not queued; the arbiter never issues one.
- Late device ready arriving in IDLE/ISSUE/RESP is ignored.
- Reset mid-transaction: FSM returns to IDLE next cycle, no response is issued, and all strobes drop.

Test Plan:
1. Read, device 1: strobe addr=0xC100_0010. D_strobe_o=4'b0010 one cycle later. Device 1 readies 3 cycles after its strobe with 0x1234_5678 -> ARB_data_ready_o pulses 1 cycle later with ARB_data_o=0x1234_5678; err_o=0.
2. Write, device 0: strobe addr=0xC000_0004, rw=1, be=4'b0011, data=0xA5A5_A5A5. D_* outputs carry exactly these values with D_strobe_o=4'b0001. Ready in the first WAIT cycle -> ARB ready pulse.
3. Unmapped addresses:
   - 0xC500_0000 (NDEV=4) -> ARB ready at T+1, data 0xDEAD_BEEF, no D_strobe, err_o=1, err_addr_o=0xC500_0000.
   - A later unmapped 0x8000_0000 keeps err_addr_o at 0xC500_0000.
4. Timeout and late ready:
   - TIMEOUT_CYCLES=8, device 2 never readies -> ARB ready exactly 8 WAIT cycles after ISSUE, data 0xDEAD_BEEF, err_o=1.
   - Device 2 readying 2 cycles later is ignored.
5. Wrong-device ready and boundary:
   - Request to device 3 while device 0 asserts ready with 0xFFFF_FFFF -> no response until device 3 readies with 0x0000_0042, and ARB_data_o=0x42.
   - Ready on the exact final count cycle returns device data, not ERR_DATA.
6. Reset mid-operation: rst_i asserted during WAIT -> next cycle all outputs 0 and FSM IDLE. A subsequent request to device 1 completes normally.
